// File: rtl/alu_issuer_pkg.sv
// alu_issuer_pkg: shared types and constants for the ALU command issuer.
//   - cmd_data layout (19 bits, MSB first):
//       {opcode[3:0], swapop, swapvl, cin, srca[2:0], srcb[2:0], dstr[2:0], dsts[2:0]}
//   - issuer FSM state encoding
//   - opcode[1:0] classes understood by the ALU (11 is rejected by the issuer)
package alu_issuer_pkg;

  localparam int CMD_W = 19;
  localparam int NREG  = 8;

  // Bit offsets of each field inside cmd_data.
  localparam int OFF_OPCODE = 15;
  localparam int OFF_SWAPOP = 14;
  localparam int OFF_SWAPVL = 13;
  localparam int OFF_CIN    = 12;
  localparam int OFF_SRCA   = 9;
  localparam int OFF_SRCB   = 6;
  localparam int OFF_DSTR   = 3;
  localparam int OFF_DSTS   = 0;

  typedef enum logic [1:0] {
    OP_FA  = 2'b00,
    OP_MUL = 2'b01,
    OP_INV = 2'b10,
    OP_ILL = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic       swapop;
    logic       swapvl;
    logic       cin;
    logic [2:0] srca;
    logic [2:0] srcb;
    logic [2:0] dstr;
    logic [2:0] dsts;
  } cmd_t;

  function automatic cmd_t cmd_decode(input logic [CMD_W-1:0] d);
    cmd_t c;
    c.opcode = d[OFF_OPCODE +: 4];
    c.swapop = d[OFF_SWAPOP];
    c.swapvl = d[OFF_SWAPVL];
    c.cin    = d[OFF_CIN];
    c.srca   = d[OFF_SRCA +: 3];
    c.srcb   = d[OFF_SRCB +: 3];
    c.dstr   = d[OFF_DSTR +: 3];
    c.dsts   = d[OFF_DSTS +: 3];
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO holding pending issuer commands.
//   clk, rst_n     : clock, asynchronous active-low reset
//   push, wdata    : write request (ignored while full)
//   pop            : remove head (ignored while empty)
//   rdata          : current head entry (valid while !empty)
//   full, empty    : occupancy flags
// DEPTH must be a power of two, at least 2.
module cmd_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra wrap bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_issuer.sv
// alu_issuer: queues ALU commands, issues them one at a time to an external
// ALU, and writes results back into an 8 x WID register file.
//   clk, rst                  : clock, asynchronous active-low reset
//   cmd_valid/cmd_data/cmd_ready : command push interface (ready = FIFO not full)
//   hw_en/hw_addr/hw_data     : host register write
//   hr_addr/hr_data           : combinational host register read
//   alu_a/b/c/en/swapop/swapvl/opcode : operands and controls to the ALU
//   alu_r/rswap/vld/status    : results and status from the ALU
//   busy, done (1-cycle pulse), err (sticky), err_clr
module alu_issuer
  import alu_issuer_pkg::*;
#(
  parameter int WID   = 256,
  parameter int DEPTH = 4,
  parameter int TMO   = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             cmd_ready,
  input  logic             hw_en,
  input  logic [2:0]       hw_addr,
  input  logic [WID-1:0]   hw_data,
  input  logic [2:0]       hr_addr,
  output logic [WID-1:0]   hr_data,
  output logic [WID-1:0]   alu_a,
  output logic [WID-1:0]   alu_b,
  output logic             alu_c,
  output logic             alu_en,
  output logic             alu_swapop,
  output logic             alu_swapvl,
  output logic [3:0]       alu_opcode,
  input  logic [WID-1:0]   alu_r,
  input  logic [WID-1:0]   alu_rswap,
  input  logic             alu_vld,
  input  logic [1:0]       alu_status,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);

  localparam int CNT_W = $clog2(TMO + 1);

  state_t           state;
  state_t           state_nx;
  logic [CMD_W-1:0] head_raw;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             err_set;
  logic             issue_ld;
  logic             capture;
  logic             wb_we;
  logic [CNT_W-1:0] cnt;
  logic [WID-1:0]   r_q;
  logic [WID-1:0]   rs_q;
  logic [WID-1:0]   rf [NREG];

  // The head stays in the FIFO until its command retires, so its fields
  // remain available for writeback without a separate command register.
  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata (cmd_data),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head      = cmd_decode(head_raw);
  assign cmd_ready = !fifo_full;
  assign hr_data   = rf[hr_addr];
  assign alu_en    = (state == S_ISSUE);
  assign done      = (state == S_WB);
  assign busy      = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no latch can form.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    err_set  = 1'b0;
    issue_ld = 1'b0;
    capture  = 1'b0;
    wb_we    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          // Illegal opcodes are dropped without waiting for the ALU.
          if (alu_op_e'(head.opcode[1:0]) == OP_ILL) begin
            pop     = 1'b1;
            err_set = 1'b1;
          end else if (alu_status == 2'b00) begin
            issue_ld = 1'b1;
            state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        // A result arriving on the last allowed cycle still counts.
        if (alu_vld) begin
          capture  = 1'b1;
          state_nx = S_WB;
        end else if (cnt == CNT_W'(TMO - 1)) begin
          err_set  = 1'b1;
          pop      = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_WB: begin
        wb_we    = 1'b1;
        pop      = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counts completed WAIT cycles; cleared everywhere else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (state == S_WAIT) cnt <= cnt + CNT_W'(1);
    else                      cnt <= '0;
  end

  // ALU-side operands load only at issue and then hold until the next issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_c      <= 1'b0;
      alu_swapop <= 1'b0;
      alu_swapvl <= 1'b0;
      alu_opcode <= '0;
      r_q        <= '0;
      rs_q       <= '0;
    end else begin
      if (issue_ld) begin
        alu_a      <= rf[head.srca];
        alu_b      <= rf[head.srcb];
        alu_c      <= head.cin;
        alu_swapop <= head.swapop;
        alu_swapvl <= head.swapvl;
        alu_opcode <= head.opcode;
      end
      if (capture) begin
        r_q  <= alu_r;
        rs_q <= alu_rswap;
      end
    end
  end

  // Writeback beats a host write to the same register; dstr beats dsts
  // when both name the same register, so only r lands there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_we && head.dstr == 3'(i))                     rf[i] <= r_q;
        else if (wb_we && head.swapop && head.dsts == 3'(i)) rf[i] <= rs_q;
        else if (hw_en && hw_addr == 3'(i))                  rf[i] <= hw_data;
      end
    end
  end

  // A new error in the same cycle as err_clr leaves err set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer: scoreboard bench for alu_issuer with a behavioural ALU.
module tb_alu_issuer;
  import alu_issuer_pkg::*;

  localparam int WID   = 256;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid, cmd_ready;
  logic [CMD_W-1:0] cmd_data;
  logic             hw_en;
  logic [2:0]       hw_addr, hr_addr;
  logic [WID-1:0]   hw_data, hr_data;
  logic [WID-1:0]   alu_a, alu_b;
  logic             alu_c, alu_en, alu_swapop, alu_swapvl;
  logic [3:0]       alu_opcode;
  logic [WID-1:0]   alu_r = '0;
  logic [WID-1:0]   alu_rswap = '0;
  logic             alu_vld = 1'b0;
  logic [1:0]       alu_status;
  logic             busy, done, err, err_clr;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]     dr;
    logic [WID-1:0] r;
    logic           has_s;
    logic [2:0]     ds;
    logic [WID-1:0] rs;
  } exp_t;
  exp_t           sb[$];
  logic [WID-1:0] mirror [8];

  logic           model_on;
  int             model_lat;
  logic           stray_vld;
  int             m_cnt = 0;
  logic [WID-1:0] m_r, m_rs;
  int             cyc = 0;
  int             vld_cyc = -1;
  int             en_cnt = 0;
  int             done_seen = 0;

  always #5 clk = ~clk;

  alu_issuer #(.WID(WID), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .hw_en(hw_en), .hw_addr(hw_addr), .hw_data(hw_data),
    .hr_addr(hr_addr), .hr_data(hr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_en(alu_en),
    .alu_swapop(alu_swapop), .alu_swapvl(alu_swapvl), .alu_opcode(alu_opcode),
    .alu_r(alu_r), .alu_rswap(alu_rswap), .alu_vld(alu_vld), .alu_status(alu_status),
    .busy(busy), .done(done), .err(err), .err_clr(err_clr)
  );

  function automatic void alu_fn(input logic [3:0] op, input logic sv, input logic c,
                                 input logic [WID-1:0] a, input logic [WID-1:0] b,
                                 output logic [WID-1:0] r, output logic [WID-1:0] rs);
    rs = a ^ b;
    case (op[1:0])
      2'b00:   r = a + b + WID'(c);
      2'b01:   r = a * b;
      default: r = ~a;
    endcase
    if (sv) begin
      r  = b;
      rs = a;
    end
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_en) en_cnt <= en_cnt + 1;
    if (done)   done_seen <= done_seen + 1;
  end

  // Behavioural ALU: drives on the falling edge, answers model_lat cycles after alu_en.
  always @(negedge clk) begin
    alu_vld = stray_vld;
    if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        alu_vld   = 1'b1;
        alu_r     = m_r;
        alu_rswap = m_rs;
        vld_cyc   = cyc + 1;
      end
    end
    if (alu_en && model_on) begin
      m_cnt = model_lat;
      alu_fn(alu_opcode, alu_swapvl, alu_c, alu_a, alu_b, m_r, m_rs);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hw_write(input logic [2:0] a, input logic [WID-1:0] v);
    hw_en = 1'b1; hw_addr = a; hw_data = v;
    tick();
    hw_en = 1'b0;
    mirror[a] = v;
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic so, input logic sv, input logic c,
                          input logic [2:0] sa, input logic [2:0] sbr, input logic [2:0] dr,
                          input logic [2:0] ds, input bit track);
    int   t;
    exp_t e;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 200) begin tick(); t++; end
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL push_ready_wait: cmd_ready=%b want 1", cmd_ready); end
    cmd_data  = {op, so, sv, c, sa, sbr, dr, ds};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    if (track && op[1:0] != 2'b11) begin
      alu_fn(op, sv, c, mirror[sa], mirror[sbr], e.r, e.rs);
      e.dr = dr; e.ds = ds; e.has_s = so && (ds != dr);
      mirror[dr] = e.r;
      if (e.has_s) mirror[ds] = e.rs;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int n);
    int   t;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      t = 0;
      while (done !== 1'b1 && t < 300) begin tick(); t++; end
      n_vec++;
      if (done !== 1'b1) begin n_bad++; $display("FAIL drain_done_wait: done=%b want 1 (cmd %0d)", done, k); return; end
      tick();
      n_vec++;
      if (done !== 1'b0) begin n_bad++; $display("FAIL done_single_pulse: done=%b want 0", done); end
      n_vec++;
      if (sb.size() == 0) begin n_bad++; $display("FAIL scoreboard_underflow: size=0 want >0"); return; end
      e = sb.pop_front();
      hr_addr = e.dr; #1;
      n_vec++;
      if (hr_data !== e.r) begin n_bad++; $display("FAIL wb_r R%0d: got %0h want %0h", e.dr, hr_data, e.r); end
      if (e.has_s) begin
        hr_addr = e.ds; #1;
        n_vec++;
        if (hr_data !== e.rs) begin n_bad++; $display("FAIL wb_rswap R%0d: got %0h want %0h", e.ds, hr_data, e.rs); end
      end
    end
  endtask

  task automatic check_regs_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      hr_addr = 3'(i); #1;
      n_vec++;
      if (hr_data !== '0) begin n_bad++; $display("FAIL %s R%0d: got %0h want 0", tag, i, hr_data); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if ({alu_en, done, err} !== 3'b000) begin n_bad++; $display("FAIL rst_ctl: got %b want 000", {alu_en, done, err}); end
    n_vec++; if (alu_a !== '0 || alu_opcode !== 4'd0) begin n_bad++; $display("FAIL rst_alu_out: a=%0h op=%0h want 0", alu_a, alu_opcode); end
    check_regs_zero("rst_reg");
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int en0, t;
    hw_write(3'd1, WID'(5));
    hw_write(3'd2, WID'(7));
    en0 = en_cnt;
    model_lat = 3;
    push_cmd(4'b0000, 0, 0, 0, 3'd1, 3'd2, 3'd3, 3'd0, 1);
    n_vec++; if (alu_en !== 1'b0) begin n_bad++; $display("FAIL basic_en_early: got %b want 0", alu_en); end
    tick();
    n_vec++; if (alu_en !== 1'b1) begin n_bad++; $display("FAIL basic_en_t2: got %b want 1", alu_en); end
    n_vec++; if (alu_a !== WID'(5) || alu_b !== WID'(7)) begin n_bad++; $display("FAIL basic_operands: a=%0h b=%0h want 5 7", alu_a, alu_b); end
    tick();
    n_vec++; if (alu_en !== 1'b0) begin n_bad++; $display("FAIL basic_en_one_cycle: got %b want 0", alu_en); end
    t = 0;
    while (done !== 1'b1 && t < 50) begin tick(); t++; end
    n_vec++; if (cyc !== vld_cyc) begin n_bad++; $display("FAIL basic_done_after_vld: done at cycle %0d want %0d", cyc, vld_cyc); end
    n_vec++; if (alu_a !== WID'(5)) begin n_bad++; $display("FAIL basic_a_stable: got %0h want 5", alu_a); end
    drain(1);
    hr_addr = 3'd3; #1;
    n_vec++; if (hr_data !== WID'(12)) begin n_bad++; $display("FAIL basic_r3: got %0h want c", hr_data); end
    n_vec++; if (en_cnt - en0 !== 1) begin n_bad++; $display("FAIL basic_en_count: got %0d want 1", en_cnt - en0); end
  endtask

  task automatic test_status_hold();
    int en0;
    en0 = en_cnt;
    alu_status = 2'b01;
    push_cmd(4'b0001, 0, 0, 0, 3'd3, 3'd1, 3'd0, 3'd0, 1);
    repeat (4) tick();
    n_vec++; if (en_cnt !== en0 || busy !== 1'b1) begin n_bad++; $display("FAIL status_hold: en=%0d busy=%b want %0d 1", en_cnt, busy, en0); end
    alu_status = 2'b00;
    drain(1);
  endtask

  task automatic test_swap();
    hw_write(3'd4, WID'('hA));
    hw_write(3'd5, WID'('hB));
    push_cmd(4'b0000, 1, 1, 0, 3'd4, 3'd5, 3'd4, 3'd5, 1);
    drain(1);
    hr_addr = 3'd4; #1;
    n_vec++; if (hr_data !== WID'('hB)) begin n_bad++; $display("FAIL swap_r4: got %0h want b", hr_data); end
    hr_addr = 3'd5; #1;
    n_vec++; if (hr_data !== WID'('hA)) begin n_bad++; $display("FAIL swap_r5: got %0h want a", hr_data); end
    // Same destination for both halves: only r lands.
    push_cmd(4'b0001, 1, 0, 1, 3'd1, 3'd2, 3'd6, 3'd6, 1);
    drain(1);
  endtask

  task automatic test_wb_conflict();
    int   t;
    exp_t e;
    push_cmd(4'b0000, 0, 0, 1, 3'd1, 3'd2, 3'd0, 3'd0, 1);
    t = 0;
    while (done !== 1'b1 && t < 50) begin tick(); t++; end
    hw_en = 1'b1; hw_addr = 3'd0; hw_data = '1;
    tick();
    hw_en = 1'b0;
    e = sb.pop_front();
    hr_addr = 3'd0; #1;
    n_vec++; if (hr_data !== e.r) begin n_bad++; $display("FAIL wb_beats_host: got %0h want %0h", hr_data, e.r); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_seen;
    model_lat = 12;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          push_cmd(4'b0000, 0, 0, 0, (k == 0) ? 3'd1 : 3'(2 + k), 3'd2, 3'(3 + k), 3'd0, 1);
          if (k == 3) begin
            n_vec++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full: cmd_ready=%b want 0", cmd_ready); end
          end
        end
      end
      drain(5);
    join
    tick();
    n_vec++; if (done_seen - d0 !== 5) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 5", done_seen - d0); end
    model_lat = 3;
  endtask

  task automatic test_illegal();
    int en0;
    en0 = en_cnt;
    err_clr = 1'b1;
    push_cmd(4'b0011, 0, 0, 0, 3'd1, 3'd2, 3'd7, 3'd0, 1);
    tick();
    err_clr = 1'b0;
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_err_set_wins: got %b want 1", err); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL illegal_dropped: busy=%b want 0", busy); end
    push_cmd(4'b0010, 0, 0, 0, 3'd5, 3'd0, 3'd7, 3'd0, 1);
    drain(1);
    n_vec++; if (en_cnt - en0 !== 1) begin n_bad++; $display("FAIL illegal_no_issue: en pulses %0d want 1", en_cnt - en0); end
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr: got %b want 0", err); end
  endtask

  task automatic test_timeout();
    int t, d0;
    hw_write(3'd7, WID'('h77));
    model_on = 1'b0;
    d0 = done_seen;
    push_cmd(4'b0000, 0, 0, 0, 3'd1, 3'd2, 3'd7, 3'd0, 0);
    t = 0;
    while (alu_en !== 1'b1 && t < 20) begin tick(); t++; end
    repeat (16) tick();
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo_early: err=%b want 0", err); end
    tick();
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo_err: err=%b want 1", err); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: busy=%b want 0", busy); end
    // A stray result while idle must be ignored.
    stray_vld = 1'b1;
    repeat (3) tick();
    stray_vld = 1'b0;
    repeat (2) tick();
    hr_addr = 3'd7; #1;
    n_vec++; if (hr_data !== WID'('h77)) begin n_bad++; $display("FAIL tmo_dst_kept: got %0h want 77", hr_data); end
    n_vec++; if (done_seen !== d0 || busy !== 1'b0) begin n_bad++; $display("FAIL stray_vld: done=%0d busy=%b want %0d 0", done_seen, busy, d0); end
    model_on = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t, d0;
    model_lat = 10;
    push_cmd(4'b0000, 0, 0, 0, 3'd1, 3'd2, 3'd3, 3'd0, 0);
    t = 0;
    while (alu_en !== 1'b1 && t < 20) begin tick(); t++; end
    repeat (2) tick();
    rst = 1'b0;
    #1;
    n_vec++; if ({alu_en, done, err, busy} !== 4'b0000) begin n_bad++; $display("FAIL midrst_ctl: got %b want 0000", {alu_en, done, err, busy}); end
    n_vec++; if (alu_a !== '0 || alu_b !== '0 || cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_out: a=%0h b=%0h ready=%b", alu_a, alu_b, cmd_ready); end
    check_regs_zero("midrst_reg");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) mirror[i] = '0;
    sb.delete();
    d0 = done_seen;
    repeat (15) tick();
    n_vec++; if (done_seen !== d0 || busy !== 1'b0) begin n_bad++; $display("FAIL late_vld: done=%0d busy=%b want %0d 0", done_seen, busy, d0); end
    check_regs_zero("late_vld_reg");
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_data = '0;
    hw_en = 1'b0; hw_addr = '0; hw_data = '0; hr_addr = '0;
    alu_status = 2'b00; err_clr = 1'b0;
    model_on = 1'b1; model_lat = 3; stray_vld = 1'b0;
    for (int i = 0; i < 8; i++) mirror[i] = '0;
    test_reset();
    test_basic();
    test_status_hold();
    test_swap();
    test_wb_conflict();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
